// File: rtl/poly_synth_pkg.sv
// Shared constants and width helpers for the polyphonic tone synthesiser.
package poly_synth_pkg;

  typedef enum logic {
    DUTY_HALF    = 1'b0,
    DUTY_QUARTER = 1'b1
  } duty_e;

  // Mixer accumulator width: one extra bit per doubling of the channel count.
  function automatic int mix_width(input int out_w, input int num_ch);
    return out_w + ((num_ch > 1) ? $clog2(num_ch) : 0);
  endfunction

  // Prescaler counter width able to hold div-1 for any div >= 1.
  function automatic int div_width(input int div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone voice: phase down-counter, attack/release envelope and registered
// signed amplitude.
module tone_channel
  import poly_synth_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int OUT_W    = 32,
  parameter int LVL_MAX  = 15,
  parameter int AMP_STEP = 20000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    env_tick,
  input  logic                    play_note,
  input  logic [PERIOD_W-1:0]     period,
  input  logic                    duty_mode,
  output logic signed [OUT_W-1:0] amp,
  output logic                    active
);
  localparam int LVL_W = (LVL_MAX > 0) ? $clog2(LVL_MAX + 1) : 1;
  localparam int MAG_W = OUT_W + LVL_W;
  localparam logic [LVL_W-1:0] LVL_TOP   = LVL_W'(LVL_MAX);
  localparam logic [MAG_W-1:0] STEP      = MAG_W'(AMP_STEP);
  localparam logic [MAG_W-1:0] MAG_LIMIT = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  logic                    play_prev;
  logic [PERIOD_W-1:0]     cnt;
  logic [PERIOD_W-1:0]     period_reg;
  logic [PERIOD_W-1:0]     thresh;
  logic [LVL_W-1:0]        level;
  logic [LVL_W-1:0]        level_next;
  logic [MAG_W-1:0]        product;
  logic signed [OUT_W-1:0] magnitude;
  logic                    note_on;
  logic                    running;
  logic                    polarity;

  assign note_on  = play_note & ~play_prev;
  assign running  = play_note | (level != '0);
  assign thresh   = (duty_mode == DUTY_QUARTER) ? (period_reg - (period_reg >> 2))
                                                : (period_reg >> 1);
  assign polarity = (cnt >= thresh);

  // Oversized steps clamp per channel so the mixer still saturates cleanly.
  assign product   = MAG_W'(level) * STEP;
  assign magnitude = (product > MAG_LIMIT) ? OUT_W'(MAG_LIMIT) : OUT_W'(product);

  always_comb begin
    level_next = level;
    if (env_tick) begin
      if (play_note && (level != LVL_TOP)) begin
        level_next = level + LVL_W'(1);
      end else if (!play_note && (level != '0)) begin
        level_next = level - LVL_W'(1);
      end
    end
  end

  // period_reg only follows the input at note-on or reload, so polarity
  // thresholds stay consistent for the whole running cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      play_prev  <= 1'b0;
      cnt        <= '0;
      period_reg <= '0;
      level      <= '0;
      amp        <= '0;
      active     <= 1'b0;
    end else begin
      play_prev <= play_note;
      level     <= level_next;
      active    <= (level_next != '0);
      if (note_on || (running && (cnt == '0))) begin
        cnt        <= period - PERIOD_W'(1);
        period_reg <= period;
      end else if (running) begin
        cnt <= cnt - PERIOD_W'(1);
      end
      if ((level == '0) || (period_reg < PERIOD_W'(2))) begin
        amp <= '0;
      end else begin
        amp <= polarity ? magnitude : -magnitude;
      end
    end
  end

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square/pulse tone synthesiser: shared prescalers, saturating
// mixer and a single-slot sample output handshake.
module poly_tone_synth
  import poly_synth_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int PERIOD_W   = 32,
  parameter int OUT_W      = 32,
  parameter int LVL_MAX    = 15,
  parameter int AMP_STEP   = 20000000,
  parameter int ENV_DIV    = 50000,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          play_note,
  input  logic [NUM_CH*PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]          duty_mode,
  input  logic                       out_allowed,
  output logic signed [OUT_W-1:0]    sample_out,
  output logic                       write_out,
  output logic [NUM_CH-1:0]          active
);
  localparam int SUM_W = mix_width(OUT_W, NUM_CH);
  localparam int ENV_W = div_width(ENV_DIV);
  localparam int SMP_W = div_width(SAMPLE_DIV);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic [ENV_W-1:0]        env_cnt;
  logic [SMP_W-1:0]        smp_cnt;
  logic                    env_tick;
  logic                    sample_tick;
  logic signed [OUT_W-1:0] amps [NUM_CH];
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] ext;
  logic signed [SUM_W-1:0] mix_sat;
  logic signed [OUT_W-1:0] mix_q;
  logic                    pending;
  logic                    fire;

  assign env_tick    = (env_cnt == ENV_W'(ENV_DIV - 1));
  assign sample_tick = (smp_cnt == SMP_W'(SAMPLE_DIV - 1));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    tone_channel #(
      .PERIOD_W (PERIOD_W),
      .OUT_W    (OUT_W),
      .LVL_MAX  (LVL_MAX),
      .AMP_STEP (AMP_STEP)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .env_tick  (env_tick),
      .play_note (play_note[gi]),
      .period    (period[gi*PERIOD_W +: PERIOD_W]),
      .duty_mode (duty_mode[gi]),
      .amp       (amps[gi]),
      .active    (active[gi])
    );
  end

  always_comb begin
    sum = '0;
    ext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ext = amps[i];
      sum = sum + ext;
    end
    if (sum > SAT_MAX) begin
      mix_sat = SAT_MAX;
    end else if (sum < SAT_MIN) begin
      mix_sat = SAT_MIN;
    end else begin
      mix_sat = sum;
    end
  end

  // A write is never issued on the cycle after another; a tick landing then
  // is parked in the pending slot instead.
  assign fire = (sample_tick | pending) & out_allowed & ~write_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      env_cnt    <= '0;
      smp_cnt    <= '0;
      mix_q      <= '0;
      pending    <= 1'b0;
      write_out  <= 1'b0;
      sample_out <= '0;
    end else begin
      env_cnt   <= env_tick ? '0 : env_cnt + ENV_W'(1);
      smp_cnt   <= sample_tick ? '0 : smp_cnt + SMP_W'(1);
      mix_q     <= OUT_W'(mix_sat);
      write_out <= fire;
      pending   <= ~fire & (pending | sample_tick);
      if (fire) begin
        sample_out <= mix_q;
      end
    end
  end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Randomised and directed checks of poly_tone_synth against a time-based
// reference model; a second instance uses a larger step to force saturation.
module tb_poly_tone_synth;
  localparam int NUM_CH = 2, PERIOD_W = 8, OUT_W = 16, LVL_MAX = 3;
  localparam int ENV_DIV = 2, SAMPLE_DIV = 4;
  localparam int STEP_A = 1000, STEP_B = 12000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0]  play_note = 2'b00;
  logic [15:0] period = 16'd0;
  logic [1:0]  duty_mode = 2'b00;
  logic        out_allowed = 1'b0;
  logic signed [15:0] sample_out, sample_out_b;
  logic        write_out, write_out_b;
  logic [1:0]  active, active_b;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state (values after the most recent clock edge)
  int m_n;
  bit m_prev [2];
  int m_ton [2], m_per [2], m_lvl [2], m_amp_a [2], m_amp_b [2];
  int m_mix_a, m_mix_b, m_so_a, m_so_b;
  bit m_pend, m_wr;

  always #5 clock = ~clock;

  poly_tone_synth #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W), .LVL_MAX(LVL_MAX),
                    .AMP_STEP(STEP_A), .ENV_DIV(ENV_DIV), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clock(clock), .reset(reset), .play_note(play_note), .period(period),
    .duty_mode(duty_mode), .out_allowed(out_allowed), .sample_out(sample_out),
    .write_out(write_out), .active(active));

  poly_tone_synth #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .OUT_W(OUT_W), .LVL_MAX(LVL_MAX),
                    .AMP_STEP(STEP_B), .ENV_DIV(ENV_DIV), .SAMPLE_DIV(SAMPLE_DIV)) dut_b (
    .clock(clock), .reset(reset), .play_note(play_note), .period(period),
    .duty_mode(duty_mode), .out_allowed(out_allowed), .sample_out(sample_out_b),
    .write_out(write_out_b), .active(active_b));

  function automatic int clamp_amp(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Signed level of a channel given the phase elapsed since its note-on.
  function automatic int unit_amp(input int ch, input int n_prev, input logic duty);
    int p, c;
    bit hi;
    if (m_lvl[ch] == 0 || m_per[ch] < 2) return 0;
    p = m_per[ch];
    c = p - 1 - ((n_prev - m_ton[ch]) % p);
    hi = duty ? (c >= p - p / 4) : (c >= p / 2);
    return hi ? m_lvl[ch] : -m_lvl[ch];
  endfunction

  task automatic model_reset();
    m_n = 0; m_mix_a = 0; m_mix_b = 0; m_so_a = 0; m_so_b = 0; m_pend = 0; m_wr = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_prev[ch] = 0; m_ton[ch] = 0; m_per[ch] = 0; m_lvl[ch] = 0;
      m_amp_a[ch] = 0; m_amp_b[ch] = 0;
    end
  endtask

  task automatic model_edge();
    int n, sa, sb, u;
    bit env, smp, fire;
    n = m_n + 1;
    m_n = n;
    env = (n % ENV_DIV) == 0;
    smp = (n % SAMPLE_DIV) == 0;
    fire = (smp || m_pend) && out_allowed && !m_wr;
    if (fire) begin
      m_so_a = m_mix_a;
      m_so_b = m_mix_b;
    end
    m_pend = !fire && (m_pend || smp);
    m_wr = fire;
    sa = 0; sb = 0;
    for (int ch = 0; ch < 2; ch++) begin
      sa += m_amp_a[ch];
      sb += m_amp_b[ch];
    end
    m_mix_a = sat16(sa);
    m_mix_b = sat16(sb);
    for (int ch = 0; ch < 2; ch++) begin
      u = unit_amp(ch, n - 1, duty_mode[ch]);
      m_amp_a[ch] = clamp_amp(u * STEP_A);
      m_amp_b[ch] = clamp_amp(u * STEP_B);
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (play_note[ch] && !m_prev[ch]) begin
        m_ton[ch] = n;
        m_per[ch] = int'(period[ch*8 +: 8]);
      end
      if (env) begin
        if (play_note[ch] && m_lvl[ch] < LVL_MAX) m_lvl[ch]++;
        else if (!play_note[ch] && m_lvl[ch] > 0) m_lvl[ch]--;
      end
      m_prev[ch] = play_note[ch];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sample_out got=%0d expected=0", sample_out); end
    n_checks++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL reset_write_out got=%0b expected=0", write_out); end
    n_checks++; if (active !== 2'b00) begin n_fail++; $display("FAIL reset_active got=%b expected=00", active); end
    n_checks++; if (sample_out_b !== 16'sd0) begin n_fail++; $display("FAIL reset_sample_out_b got=%0d expected=0", sample_out_b); end
    model_reset();
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_tone();
    int hi, lo;
    period = {8'd8, 8'd8};
    duty_mode = 2'b00;
    out_allowed = 1'b1;
    play_note = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (dut.gen_ch[0].u_ch.level !== 2'd3) begin n_fail++; $display("FAIL tone_level got=%0d expected=3", dut.gen_ch[0].u_ch.level); end
    n_checks++; if (active !== 2'b01) begin n_fail++; $display("FAIL tone_active got=%b expected=01", active); end
    hi = 0; lo = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dut.gen_ch[0].u_ch.amp == 16'sd3000) hi++;
      if (dut.gen_ch[0].u_ch.amp == -16'sd3000) lo++;
      n_checks++;
      if (int'(dut.gen_ch[0].u_ch.amp) !== m_amp_a[0]) begin
        n_fail++; $display("FAIL tone_amp cyc=%0d got=%0d expected=%0d", m_n, dut.gen_ch[0].u_ch.amp, m_amp_a[0]);
      end
    end
    n_checks++; if (hi !== 4 || lo !== 4) begin n_fail++; $display("FAIL tone_duty50 got_hi=%0d got_lo=%0d expected=4/4", hi, lo); end
    $display("test_tone done hi=%0d lo=%0d", hi, lo);
  endtask

  task automatic test_pulse();
    int hi, lo;
    duty_mode = 2'b01;
    tick();
    hi = 0; lo = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dut.gen_ch[0].u_ch.amp == 16'sd3000) hi++;
      if (dut.gen_ch[0].u_ch.amp == -16'sd3000) lo++;
      n_checks++;
      if (int'(dut.gen_ch[0].u_ch.amp) !== m_amp_a[0]) begin
        n_fail++; $display("FAIL pulse_amp cyc=%0d got=%0d expected=%0d", m_n, dut.gen_ch[0].u_ch.amp, m_amp_a[0]);
      end
    end
    n_checks++; if (hi !== 2 || lo !== 6) begin n_fail++; $display("FAIL pulse_duty25 got_hi=%0d got_lo=%0d expected=2/6", hi, lo); end
    $display("test_pulse done hi=%0d lo=%0d", hi, lo);
  endtask

  task automatic test_release();
    int seen [$];
    int last;
    duty_mode = 2'b00;
    play_note = 2'b00;
    last = 3;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (int'(dut.gen_ch[0].u_ch.level) !== m_lvl[0]) begin
        n_fail++; $display("FAIL release_level cyc=%0d got=%0d expected=%0d", m_n, dut.gen_ch[0].u_ch.level, m_lvl[0]);
      end
      if (int'(dut.gen_ch[0].u_ch.level) != last) begin
        last = int'(dut.gen_ch[0].u_ch.level);
        seen.push_back(last);
      end
    end
    n_checks++;
    if (seen.size() != 3 || seen[0] != 2 || seen[1] != 1 || seen[2] != 0) begin
      n_fail++; $display("FAIL release_sequence got_len=%0d expected=2,1,0", seen.size());
    end
    n_checks++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL release_active got=%b expected=0", active[0]); end
    n_checks++; if (dut.gen_ch[0].u_ch.amp !== 16'sd0) begin n_fail++; $display("FAIL release_amp got=%0d expected=0", dut.gen_ch[0].u_ch.amp); end
    $display("test_release done");
  endtask

  task automatic test_saturation();
    int mx, mn;
    play_note = 2'b11;
    for (int i = 0; i < 8; i++) tick();
    mx = -100000; mn = 100000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int'(dut_b.mix_q) > mx) mx = int'(dut_b.mix_q);
      if (int'(dut_b.mix_q) < mn) mn = int'(dut_b.mix_q);
      n_checks++;
      if (int'(dut_b.mix_q) !== m_mix_b || int'(dut.mix_q) !== m_mix_a) begin
        n_fail++; $display("FAIL sat_mix cyc=%0d got=%0d/%0d expected=%0d/%0d", m_n, dut.mix_q, dut_b.mix_q, m_mix_a, m_mix_b);
      end
    end
    n_checks++; if (mx !== 32767) begin n_fail++; $display("FAIL sat_high got=%0d expected=32767", mx); end
    n_checks++; if (mn !== -32768) begin n_fail++; $display("FAIL sat_low got=%0d expected=-32768", mn); end
    $display("test_saturation done max=%0d min=%0d", mx, mn);
  endtask

  task automatic test_backpressure();
    int writes;
    out_allowed = 1'b0;
    writes = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (write_out) writes++;
    end
    for (int i = 0; i < 8 && (m_n % SAMPLE_DIV) != 0; i++) tick();
    n_checks++; if (writes !== 0) begin n_fail++; $display("FAIL bp_blocked got=%0d writes expected=0", writes); end
    out_allowed = 1'b1;
    tick();
    n_checks++; if (write_out !== 1'b1) begin n_fail++; $display("FAIL bp_release_write got=%0b expected=1", write_out); end
    n_checks++;
    if (int'(sample_out) !== m_so_a || int'(sample_out_b) !== m_so_b) begin
      n_fail++; $display("FAIL bp_sample got=%0d/%0d expected=%0d/%0d", sample_out, sample_out_b, m_so_a, m_so_b);
    end
    writes = int'(write_out);
    tick(); if (write_out) writes++;
    tick(); if (write_out) writes++;
    n_checks++; if (writes !== 1) begin n_fail++; $display("FAIL bp_single_write got=%0d expected=1", writes); end
    $display("test_backpressure done sample=%0d", sample_out);
  endtask

  task automatic test_reset_midnote();
    play_note = 2'b11;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (sample_out !== 16'sd0 || write_out !== 1'b0 || active !== 2'b00) begin
      n_fail++; $display("FAIL midreset_outputs got=%0d/%0b/%b expected=0/0/00", sample_out, write_out, active);
    end
    n_checks++; if (dut.gen_ch[0].u_ch.amp !== 16'sd0) begin n_fail++; $display("FAIL midreset_amp got=%0d expected=0", dut.gen_ch[0].u_ch.amp); end
    play_note = 2'b01;
    tick();
    tick();
    model_reset();
    reset = 1'b0;
    tick();
    n_checks++; if (dut.gen_ch[0].u_ch.cnt !== 8'd7) begin n_fail++; $display("FAIL midreset_cnt got=%0d expected=7", dut.gen_ch[0].u_ch.cnt); end
    n_checks++; if (dut.gen_ch[0].u_ch.level !== 2'd0) begin n_fail++; $display("FAIL midreset_level0 got=%0d expected=0", dut.gen_ch[0].u_ch.level); end
    tick();
    n_checks++; if (dut.gen_ch[0].u_ch.level !== 2'd1 || active !== 2'b01) begin
      n_fail++; $display("FAIL midreset_ramp got=%0d/%b expected=1/01", dut.gen_ch[0].u_ch.level, active);
    end
    $display("test_reset_midnote done");
  endtask

  task automatic test_random();
    bit wr_prev;
    for (int seg = 0; seg < 4; seg++) begin
      play_note = 2'b00;
      period = {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
      duty_mode = 2'($urandom_range(0, 3));
      do_reset();
      wr_prev = 1'b0;
      for (int c = 0; c < 250; c++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if ($urandom_range(0, 11) == 0) play_note[ch] = ~play_note[ch];
          if ($urandom_range(0, 40) == 0) duty_mode[ch] = ~duty_mode[ch];
        end
        out_allowed = ($urandom_range(0, 3) != 0);
        tick();
        n_checks++;
        if (int'(sample_out) !== m_so_a || int'(sample_out_b) !== m_so_b) begin
          n_fail++; $display("FAIL rand_sample seg=%0d cyc=%0d got=%0d/%0d expected=%0d/%0d", seg, m_n, sample_out, sample_out_b, m_so_a, m_so_b);
        end
        n_checks++;
        if (write_out !== m_wr || write_out_b !== m_wr) begin
          n_fail++; $display("FAIL rand_write seg=%0d cyc=%0d got=%0b/%0b expected=%0b", seg, m_n, write_out, write_out_b, m_wr);
        end
        n_checks++;
        if (active !== {m_lvl[1] != 0, m_lvl[0] != 0}) begin
          n_fail++; $display("FAIL rand_active seg=%0d cyc=%0d got=%b expected=%b", seg, m_n, active, {m_lvl[1] != 0, m_lvl[0] != 0});
        end
        n_checks++;
        if (write_out && wr_prev) begin
          n_fail++; $display("FAIL rand_back_to_back seg=%0d cyc=%0d got=11 expected=no consecutive writes", seg, m_n);
        end
        wr_prev = write_out;
      end
      $display("test_random segment %0d done periods=%0d/%0d", seg, period[7:0], period[15:8]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tone();
    test_pulse();
    test_release();
    test_saturation();
    test_backpressure();
    test_reset_midnote();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
